// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: instruction field positions, forward-select
// encodings and the shadow-stage records used by the hazard unit.
package riscv_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      we;
        logic      m2r;
    } ex_stage_t;

    typedef struct packed {
        reg_addr_t rd;
        logic      we;
        logic      m2r;
    } mem_stage_t;

    typedef struct packed {
        reg_addr_t rd;
        logic      we;
    } wb_stage_t;

endpackage

// File: rtl/fwd_select.sv
// ALU operand forward select: MEM producer beats WB producer; x0 never forwards.
module fwd_select
    import riscv_pkg::*;
(
    input  reg_addr_t  rs_i,
    input  reg_addr_t  mem_rd_i,
    input  logic       mem_we_i,
    input  reg_addr_t  wb_rd_i,
    input  logic       wb_we_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (mem_we_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard detection and forwarding control. Tracks EX/MEM/WB destination
// info in shadow registers and derives stalls, flushes and forward selects.
module hazard_forward_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instruction_i,
    input  logic        id_valid_i,
    input  logic        id_rd_we_i,
    input  logic        id_mem_to_reg_i,
    input  logic        id_branch_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        branch_condition_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic [1:0]  alu_forward_a_o,
    output logic [1:0]  alu_forward_b_o,
    output logic        branch_forward_a_o,
    output logic        branch_forward_b_o
);

    if (XLEN < 32) begin : g_xlen_too_small
        $error("hazard_forward_unit: XLEN must be at least 32");
    end

    ex_stage_t  ex_q, ex_d;
    mem_stage_t mem_q;
    wb_stage_t  wb_q;

    reg_addr_t  id_rs1, id_rs2, id_rd;
    logic       ex_hit, mem_hit, stall;
    logic [1:0] fwd_a, fwd_b;
    logic       unused_ins;

    assign id_rs1 = id_instruction_i[RS1_LSB +: REG_AW];
    assign id_rs2 = id_instruction_i[RS2_LSB +: REG_AW];
    assign id_rd  = id_instruction_i[RD_LSB +: REG_AW];
    assign unused_ins = ^{id_instruction_i[31:25], id_instruction_i[14:12],
                          id_instruction_i[6:0]};

    // A used ID source register matches a live (non-x0) producer in EX / MEM.
    assign ex_hit = ex_q.we && (ex_q.rd != '0) &&
                    ((id_uses_rs1_i && (ex_q.rd == id_rs1)) ||
                     (id_uses_rs2_i && (ex_q.rd == id_rs2)));
    assign mem_hit = mem_q.we && (mem_q.rd != '0) &&
                     ((id_uses_rs1_i && (mem_q.rd == id_rs1)) ||
                      (id_uses_rs2_i && (mem_q.rd == id_rs2)));

    // Held low while rst_n is low so outputs sit at their idle values during reset.
    assign stall = rst_n && id_valid_i &&
                   ((ex_hit && ex_q.m2r) ||
                    (id_branch_i && ex_hit) ||
                    (id_branch_i && mem_hit && mem_q.m2r));

    always_comb begin
        ex_d = '0;
        if (id_valid_i && !stall) begin
            ex_d = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                     we: id_rd_we_i, m2r: id_mem_to_reg_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{rd: ex_q.rd, we: ex_q.we, m2r: ex_q.m2r};
            wb_q  <= '{rd: mem_q.rd, we: mem_q.we};
        end
    end

    fwd_select u_fwd_a (
        .rs_i     (ex_q.rs1),
        .mem_rd_i (mem_q.rd),
        .mem_we_i (mem_q.we),
        .wb_rd_i  (wb_q.rd),
        .wb_we_i  (wb_q.we),
        .sel_o    (fwd_a)
    );

    fwd_select u_fwd_b (
        .rs_i     (ex_q.rs2),
        .mem_rd_i (mem_q.rd),
        .mem_we_i (mem_q.we),
        .wb_rd_i  (wb_q.rd),
        .wb_we_i  (wb_q.we),
        .sel_o    (fwd_b)
    );

    always_comb begin
        pc_en_o            = !stall;
        if_id_en_o         = !stall;
        id_ex_flush_o      = stall;
        if_id_flush_o      = rst_n && id_branch_i && branch_condition_i && !stall;
        alu_forward_a_o    = rst_n ? fwd_a : FWD_REG;
        alu_forward_b_o    = rst_n ? fwd_b : FWD_REG;
        branch_forward_a_o = rst_n && id_branch_i && mem_q.we && !mem_q.m2r &&
                             (mem_q.rd != '0) && (mem_q.rd == id_rs1);
        branch_forward_b_o = rst_n && id_branch_i && mem_q.we && !mem_q.m2r &&
                             (mem_q.rd != '0) && (mem_q.rd == id_rs2);
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: each step drives ID, queues the expected
// control outputs and checks them mid-cycle against the DUT.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ins;
    logic        v, we, m2r, br, u1, u2, cond;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, bfa, bfb;
    logic [1:0]  fa, fb;

    typedef struct packed {
        logic       pc_en;
        logic       if_id_en;
        logic       if_id_flush;
        logic       id_ex_flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       bfa;
        logic       bfb;
    } out_t;

    typedef struct {
        string tag;
        out_t  exp;
    } sb_t;

    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    out_t obs;

    always #5 clk = ~clk;

    hazard_forward_unit #(.XLEN(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .id_instruction_i   (ins),
        .id_valid_i         (v),
        .id_rd_we_i         (we),
        .id_mem_to_reg_i    (m2r),
        .id_branch_i        (br),
        .id_uses_rs1_i      (u1),
        .id_uses_rs2_i      (u2),
        .branch_condition_i (cond),
        .pc_en_o            (pc_en),
        .if_id_en_o         (if_id_en),
        .if_id_flush_o      (if_id_flush),
        .id_ex_flush_o      (id_ex_flush),
        .alu_forward_a_o    (fa),
        .alu_forward_b_o    (fb),
        .branch_forward_a_o (bfa),
        .branch_forward_b_o (bfb)
    );

    assign obs = '{pc_en: pc_en, if_id_en: if_id_en, if_id_flush: if_id_flush,
                   id_ex_flush: id_ex_flush, fa: fa, fb: fb, bfa: bfa, bfb: bfb};

    function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic out_t mk(input logic stall, input logic flush, input logic [1:0] xa,
                                input logic [1:0] xb, input logic ba, input logic bb);
        return '{pc_en: !stall, if_id_en: !stall, if_id_flush: flush, id_ex_flush: stall,
                 fa: xa, fb: xb, bfa: ba, bfb: bb};
    endfunction

    task automatic drive(input logic r, input logic [31:0] i, input logic vv, input logic w,
                         input logic m, input logic b, input logic a1, input logic a2,
                         input logic c, input string tag, input out_t e);
        sb_t s;
        rst_n = r; ins = i; v = vv; we = w; m2r = m; br = b; u1 = a1; u2 = a2; cond = c;
        s.tag = tag;
        s.exp = e;
        sb.push_back(s);
    endtask

    task automatic check();
        sb_t s;
        #3;
        s = sb.pop_front();
        n_cmp++;
        assert (obs === s.exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b required %b", s.tag, obs, s.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic [31:0] i, input logic vv, input logic w,
                        input logic m, input logic b, input logic a1, input logic a2,
                        input logic c, input string tag, input out_t e);
        drive(r, i, vv, w, m, b, a1, a2, c, tag, e);
        check();
        tick();
    endtask

    initial begin
        out_t d, st;
        d  = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        st = mk(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // reset, with a taken branch in ID that must not leak through
        step(0, r_ins(0, 1, 2), 1, 0, 0, 1, 1, 1, 1, "reset_hold", d);
        step(1, '0, 0, 0, 0, 0, 0, 0, 0, "after_reset", d);

        // add x5,x1,x2 ; sub x6,x5,x3
        step(1, r_ins(5, 1, 2), 1, 1, 0, 0, 1, 1, 0, "add_x5_id", d);
        step(1, r_ins(6, 5, 3), 1, 1, 0, 0, 1, 1, 0, "sub_id_no_stall", d);
        step(1, '0, 0, 0, 0, 0, 0, 0, 0, "sub_ex_fwd_mem", mk(0, 0, 2'b10, 2'b00, 0, 0));

        // add x5 ; nop ; or x7,x5,x5
        step(1, r_ins(5, 1, 2), 1, 1, 0, 0, 1, 1, 0, "add_x5_b", d);
        step(1, '0, 0, 0, 0, 0, 0, 0, 0, "nop_b", d);
        step(1, r_ins(7, 5, 5), 1, 1, 0, 0, 1, 1, 0, "or_id", d);
        step(1, r_ins(5, 1, 2), 1, 1, 0, 0, 1, 1, 0, "or_ex_fwd_wb", mk(0, 0, 2'b01, 2'b01, 0, 0));

        // add x5 ; add x5 ; or x7,x5,x5 -> MEM beats WB
        step(1, r_ins(5, 1, 2), 1, 1, 0, 0, 1, 1, 0, "add_x5_c", d);
        step(1, r_ins(7, 5, 5), 1, 1, 0, 0, 1, 1, 0, "or_id_c", d);
        step(1, '0, 0, 0, 0, 0, 0, 0, 0, "mem_over_wb", mk(0, 0, 2'b10, 2'b10, 0, 0));

        // lw x4,0(x0) ; add x8,x4,x1
        step(1, r_ins(4, 0, 0), 1, 1, 1, 0, 1, 0, 0, "lw_id", d);
        step(1, r_ins(8, 4, 1), 1, 1, 0, 0, 1, 1, 0, "load_use_stall", st);
        step(1, r_ins(8, 4, 1), 1, 1, 0, 0, 1, 1, 0, "load_use_release", d);
        step(1, '0, 0, 0, 0, 0, 0, 0, 0, "load_use_fwd_wb", mk(0, 0, 2'b01, 2'b00, 0, 0));

        // lw x4 ; beq x4,x0 (taken) -> two stalls, flush held off until the stall clears
        step(1, r_ins(4, 0, 0), 1, 1, 1, 0, 1, 0, 0, "lw_id_b", d);
        step(1, r_ins(0, 4, 0), 1, 0, 0, 1, 1, 1, 1, "beq_stall_ex_load", st);
        step(1, r_ins(0, 4, 0), 1, 0, 0, 1, 1, 1, 1, "beq_stall_mem_load", st);
        step(1, r_ins(0, 4, 0), 1, 0, 0, 1, 1, 1, 1, "beq_taken_flush", mk(0, 1, 2'b00, 2'b00, 0, 0));

        // addi x4,x1 ; beq x4,x0 -> one stall then branch forward from MEM
        step(1, r_ins(4, 1, 0), 1, 1, 0, 0, 1, 0, 0, "addi_id", d);
        step(1, r_ins(0, 4, 0), 1, 0, 0, 1, 1, 1, 0, "beq_stall_ex_alu", st);
        step(1, r_ins(0, 4, 0), 1, 0, 0, 1, 1, 1, 0, "beq_fwd_mem", mk(0, 0, 2'b00, 2'b00, 1, 0));

        // add x0,x1,x2 ; use x0 -> no forwarding, no stall
        step(1, r_ins(0, 1, 2), 1, 1, 0, 0, 1, 1, 0, "add_x0_id", mk(0, 0, 2'b01, 2'b00, 0, 0));
        step(1, r_ins(9, 0, 0), 1, 1, 0, 0, 1, 1, 0, "use_x0_id", d);
        step(1, r_ins(0, 0, 0), 1, 0, 0, 1, 1, 1, 1, "x0_mem_ignored", mk(0, 1, 2'b00, 2'b00, 0, 0));
        step(1, '0, 0, 0, 0, 0, 0, 0, 0, "x0_wb_ignored", d);

        // reset for one clock during a load-use stall
        step(1, r_ins(4, 0, 0), 1, 1, 1, 0, 1, 0, 0, "lw_id_c", d);
        drive(1, r_ins(8, 4, 1), 1, 1, 0, 0, 1, 1, 0, "stall_before_reset", st);
        check();
        drive(0, r_ins(8, 4, 1), 1, 1, 0, 0, 1, 1, 0, "reset_in_stall", d);
        check();
        tick();
        step(1, r_ins(8, 4, 1), 1, 1, 0, 0, 1, 1, 0, "post_reset_no_stall", d);
        step(1, '0, 0, 0, 0, 0, 0, 0, 0, "post_reset_empty", d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
